// File: rtl/csi_rx_ctrl_pkg.sv
// csi_rx_ctrl_pkg: shared state encoding and error bit indices for the capture sequencer
package csi_rx_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_FS = 2'd1,
        CAPTURE = 2'd2,
        RECOVER = 2'd3
    } state_t;
    localparam int ERR_LINE_LEN  = 0;
    localparam int ERR_FRAME_LEN = 1;
    localparam int ERR_TIMEOUT   = 2;
endpackage

// File: rtl/csi_rx_watchdog.sv
// csi_rx_watchdog: clear/increment counter that pulses tc on its TIMEOUT-th uncleared cycle
module csi_rx_watchdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tc
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clear ? '0 : cnt_q + W'(1);
        tc    = ~clear & (cnt_q == LAST);
    end
    always_ff @(posedge clock) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/csi_rx_capture_ctrl.sv
// csi_rx_capture_ctrl: CSI-2 frame-capture sequencer with dimension checks and link watchdog
module csi_rx_capture_ctrl
    import csi_rx_ctrl_pkg::*;
#(
    parameter int TIMEOUT    = 65535,
    parameter int RST_CYCLES = 16,
    parameter int CW         = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          capture_req,
    input  logic          continuous,
    input  logic          abort,
    input  logic [CW-1:0] expected_words,
    input  logic [CW-1:0] expected_lines,
    input  logic          vsync,
    input  logic          in_frame,
    input  logic          in_line,
    input  logic          payload_enable,
    output logic          capture_en,
    output logic          datapath_reset,
    output logic          frame_active,
    output logic          frame_done,
    output logic [2:0]    err_flags,
    output logic [CW-1:0] line_count
);
    state_t state_q, state_d;
    logic vsync_q, in_frame_q, in_line_q;
    logic [CW-1:0] word_cnt_q, word_cnt_d, line_count_q, line_count_d, line_inc, line_next;
    logic [2:0] err_flags_q, err_flags_d;
    logic capture_en_q, capture_en_d, frame_active_q, frame_active_d;
    logic frame_done_q, frame_done_d, datapath_reset_q, datapath_reset_d;
    logic vs_rise, vs_edge, line_fall, frame_fall, armed, wd_tc, rst_tc;
    assign vs_rise    = vsync & ~vsync_q;
    assign vs_edge    = vsync ^ vsync_q;
    assign line_fall  = ~in_line & in_line_q;
    assign frame_fall = ~in_frame & in_frame_q;
    assign armed      = (state_q == WAIT_FS) || (state_q == CAPTURE);
    assign line_inc   = &line_count_q ? line_count_q : line_count_q + CW'(1);
    assign line_next  = line_fall ? line_inc : line_count_q;
    csi_rx_watchdog #(.TIMEOUT(TIMEOUT)) u_link_wd (
        .clock (clock),
        .reset (reset),
        .clear (~armed | payload_enable | vs_edge),
        .tc    (wd_tc)
    );
    csi_rx_watchdog #(.TIMEOUT(RST_CYCLES)) u_rst_cnt (
        .clock (clock),
        .reset (reset),
        .clear (state_q != RECOVER),
        .tc    (rst_tc)
    );
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        line_count_d   = line_count_q;
        err_flags_d    = err_flags_q;
        capture_en_d   = capture_en_q;
        frame_active_d = frame_active_q;
        frame_done_d   = 1'b0;
        if (abort) begin
            state_d        = IDLE;
            capture_en_d   = 1'b0;
            frame_active_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture_req) begin
                        state_d      = WAIT_FS;
                        err_flags_d  = '0;
                        line_count_d = '0;
                    end
                end
                WAIT_FS: begin
                    if (wd_tc) begin
                        state_d = RECOVER;
                    end else if (vs_rise) begin
                        state_d        = CAPTURE;
                        capture_en_d   = 1'b1;
                        frame_active_d = 1'b1;
                        word_cnt_d     = '0;
                        line_count_d   = '0;
                    end
                end
                CAPTURE: begin
                    if (wd_tc) begin
                        state_d                  = RECOVER;
                        err_flags_d[ERR_TIMEOUT] = 1'b1;
                        capture_en_d             = 1'b0;
                        frame_active_d           = 1'b0;
                    end else if (vs_rise) begin
                        err_flags_d[ERR_FRAME_LEN] = 1'b1;
                        frame_done_d               = 1'b1;
                        word_cnt_d                 = '0;
                        line_count_d               = '0;
                    end else begin
                        if (payload_enable && in_line && !(&word_cnt_q))
                            word_cnt_d = word_cnt_q + CW'(1);
                        if (line_fall) begin
                            if (word_cnt_q != expected_words)
                                err_flags_d[ERR_LINE_LEN] = 1'b1;
                            line_count_d = line_inc;
                            word_cnt_d   = '0;
                        end
                        if (frame_fall) begin
                            if (line_next != expected_lines)
                                err_flags_d[ERR_FRAME_LEN] = 1'b1;
                            frame_done_d   = 1'b1;
                            capture_en_d   = 1'b0;
                            frame_active_d = 1'b0;
                            state_d        = continuous ? WAIT_FS : IDLE;
                        end
                    end
                end
                RECOVER: begin
                    if (rst_tc)
                        state_d = continuous ? WAIT_FS : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        datapath_reset_d = (state_d == RECOVER);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            vsync_q          <= 1'b0;
            in_frame_q       <= 1'b0;
            in_line_q        <= 1'b0;
            word_cnt_q       <= '0;
            line_count_q     <= '0;
            err_flags_q      <= '0;
            capture_en_q     <= 1'b0;
            frame_active_q   <= 1'b0;
            frame_done_q     <= 1'b0;
            datapath_reset_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vsync_q          <= vsync;
            in_frame_q       <= in_frame;
            in_line_q        <= in_line;
            word_cnt_q       <= word_cnt_d;
            line_count_q     <= line_count_d;
            err_flags_q      <= err_flags_d;
            capture_en_q     <= capture_en_d;
            frame_active_q   <= frame_active_d;
            frame_done_q     <= frame_done_d;
            datapath_reset_q <= datapath_reset_d;
        end
    end
    assign capture_en     = capture_en_q;
    assign datapath_reset = datapath_reset_q;
    assign frame_active   = frame_active_q;
    assign frame_done     = frame_done_q;
    assign err_flags      = err_flags_q;
    assign line_count     = line_count_q;
endmodule
